shift_exec_stage: RTL and testbench
===================================

// Module: shift_exec_stage
// PURPOSE
//   Execute-stage wrapper around barrelshifter32 for RV32I SLL/SRL/SRA (R-type) and SLLI/SRLI/SRAI (I-type).
//   Accepts decoded shift ops from decode (valid/ready), selects the operand and decodes direction/arith.
//   Drives the shifter from a registered issue stage, then registers the result toward writeback.
//   Two pipeline stages (S1 issue, S2 result), full throughput, backpressure-safe.
// PARAMETERS
//   XLEN        32   datapath width; only 32 is supported (barrelshifter32 is fixed-width)
//   RD_W        5    destination register index width
// PORTS
//   clk           in   1     rising-edge clock
//   rst           in   1     synchronous reset, active-high
//   flush         in   1     kill all in-flight ops (branch redirect)
//   in_valid      in   1     decode presents an op
//   in_ready      out  1     stage accepts op this cycle
//   in_opcode     in   7     0110011 = R-type, 0010011 = I-type
//   in_func3      in   3     001 = left, 101 = right
//   in_func7      in   7     0000000 = logical, 0100000 = arithmetic
//   in_rs1_val    in   32    value to shift
//   in_rs2_val    in   32    R-type shift amount source; bits [4:0] used
//   in_shamt_imm  in   5     I-type shift amount (instr[24:20])
//   in_rd         in   5     destination register
//   out_valid     out  1     result valid
//   out_ready     in   1     writeback accepts result
//   out_result    out  32    shifted value
//   out_rd        out  5     destination register
//   out_illegal   out  1     only with SHIFT_ILLEGAL_CHECK_EN; tied 0 otherwise
// BEHAVIOUR
//   Clock/reset: one clock; reset is synchronous, active-high. Reset clears s1_valid, s2_valid,
//     out_result=0, out_rd=0, out_illegal=0; in_ready=1 on the first cycle after reset.
//   Handshake: transfer on valid&&ready, both sides. out_valid/out_result/out_rd must hold
//     stable while out_valid && !out_ready.
//   S2 loads when !s2_valid || out_ready. S1 advances into S2 on that same condition.
//     in_ready = !s1_valid || s2_load (combinational, no input-to-ready path).
//   Latency: accept at cycle N -> out_valid at N+2 if there is no stall. Throughput is one op/cycle.
//   Shift amount: R-type uses in_rs2_val[4:0]; I-type uses in_shamt_imm. Bits [31:5] of rs2 are ignored.
//   Direction and mode: is_left = (func3==001); is_sra = func7[5] && !is_left. A left shift with
//     func7[5]=1 is a logical left shift.
//   Op filtering: an op with an opcode other than the two above, or func3 not in {001,101}, is consumed
//     (in_ready honoured) and produces no output.
//   Flush: clears s1_valid and s2_valid in the same cycle. Flush takes priority over a
//     simultaneous accept, so an op presented in the flush cycle is dropped. in_ready=1 during flush.
//   Reset has priority over flush. Reset mid-stall drops all ops and produces no output.
//   Boundaries: shamt=0 passes the value through unchanged. SRA by 31 yields a sign fill.
//     Back-to-back ops under an out_ready toggle must neither duplicate nor drop ops.
// CONFIGURATION
//   SHIFT_ILLEGAL_CHECK_EN defined: bad func7 or bad opcode/func3 ops are not dropped. They flow
//     through with out_valid=1, out_illegal=1, out_result=0.
//     Bad func7 means: anything other than 0000000/0100000, or 0100000 with func3=001.
//   SHIFT_ILLEGAL_CHECK_EN undefined: the filtering/decoding above applies and out_illegal is tied 0.
// STRUCTURE
//   rv32_pkg (shared include): OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011, F3_SLL=3'b001,
//     F3_SRL_SRA=3'b101, F7_BASE=7'b0000000, F7_ALT=7'b0100000.
//   One sub-module: the existing barrelshifter32 (.i, .s, .func3=is_left, .func7=is_sra, .o),
//     fed from S1 registers. Its output is captured into S2.
//   No other hierarchy; handshake and decode are kept local.
// TESTING
//   SLLI rs1=0x00000001 imm=4 -> out_result=0x00000010 exactly 2 cycles after accept.
//   SRL rs1=0xF0000000 rs2=0xFFFFFFE4 (amt 4) -> 0x0F000000; SRA same operands -> 0xFF000000.
//   SRAI rs1=0x80000000 imm=31 -> 0xFFFFFFFF; SLL with amt 0 -> value unchanged.
//   Stream 8 ops with out_ready held low for 3 cycles mid-stream -> all 8 results in order, none lost or
//     duplicated, outputs stable while stalled.
//   Flush while S1 and S2 are both full, with in_valid high -> no out_valid for those 3 ops; the next op
//     issues normally.
//   Op opcode 0110111 or func7 0000001 -> no output; with SHIFT_ILLEGAL_CHECK_EN -> out_illegal=1,
//     result 0.

Source files
------------

// File: rtl/shift_exec_stage_pkg.sv
// Shared RV32I shift-op encodings and the issue-stage record for shift_exec_stage.
// Optional illegal-op reporting is enabled with SHIFT_ILLEGAL_CHECK_EN.
package shift_exec_stage_pkg;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [4:0]      amt;
        logic            is_left;
        logic            is_sra;
        logic [RD_W-1:0] rd;
    } issue_t;

endpackage

// File: rtl/shift_exec_stage_barrelshifter32.sv
// 32-bit barrel shifter: five log stages of right shift, with left shifts done by bit reversal.
// func3 selects left, func7 selects arithmetic right.
module barrelshifter32 (
    input  logic [31:0] i,
    input  logic [4:0]  s,
    input  logic        func3,
    input  logic        func7,
    output logic [31:0] o
);

    logic [31:0] st [6];
    logic        fill;

    function automatic logic [31:0] rev(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = v[31-k];
        return r;
    endfunction

    assign fill  = func7 & ~func3 & i[31];
    assign st[0] = func3 ? rev(i) : i;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        assign st[k+1] = s[k] ? {{(1 << k){fill}}, st[k][31:(1 << k)]} : st[k];
    end

    assign o = func3 ? rev(st[5]) : st[5];

endmodule

// File: rtl/shift_exec_stage.sv
// RV32I shift execute stage: S1 issue register feeding barrelshifter32, S2 result register.
// Define SHIFT_ILLEGAL_CHECK_EN to pass bad ops through flagged on out_illegal instead of dropping them.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_func3,
    input  logic [6:0]      in_func7,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [4:0]      in_shamt_imm,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_illegal
);

    logic            opc_ok, f3_ok, f7_known, keep, accept, s2_load;
    logic            s1_valid, s2_valid;
    issue_t          dec, s1_q;
    logic [XLEN-1:0] shift_o;
    logic            unused_rs2_hi;

    assign unused_rs2_hi = &{1'b0, in_rs2_val[XLEN-1:5]};

    assign opc_ok   = (in_opcode == OPC_OP) || (in_opcode == OPC_OP_IMM);
    assign f3_ok    = (in_func3 == F3_SLL) || (in_func3 == F3_SRL_SRA);
    assign f7_known = (in_func7 == F7_BASE) || (in_func7 == F7_ALT);

    always_comb begin
        dec         = '0;
        dec.rs1     = in_rs1_val;
        dec.amt     = (in_opcode == OPC_OP) ? in_rs2_val[4:0] : in_shamt_imm;
        dec.is_left = (in_func3 == F3_SLL);
        dec.is_sra  = in_func7[5] && (in_func3 != F3_SLL);
        dec.rd      = in_rd;
    end

    // Flush forces ready so decode is never held while the pipe is being emptied.
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = flush || !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

`ifdef SHIFT_ILLEGAL_CHECK_EN
    logic dec_illegal, s1_illegal, s2_illegal;

    assign dec_illegal = !(opc_ok && f3_ok) || !f7_known ||
                         ((in_func7 == F7_ALT) && (in_func3 == F3_SLL));
    assign keep        = 1'b1;
    assign out_illegal = s2_illegal;
`else
    assign keep        = opc_ok && f3_ok && f7_known;
    assign out_illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= keep;
            s1_q     <= dec;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    barrelshifter32 u_shifter (
        .i     (s1_q.rs1),
        .s     (s1_q.amt),
        .func3 (s1_q.is_left),
        .func7 (s1_q.is_sra),
        .o     (shift_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
`ifdef SHIFT_ILLEGAL_CHECK_EN
                out_result <= s1_illegal ? '0 : shift_o;
`else
                out_result <= shift_o;
`endif
                out_rd     <= s1_q.rd;
            end
        end
    end

`ifdef SHIFT_ILLEGAL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_illegal <= 1'b0;
            s2_illegal <= 1'b0;
        end else begin
            if (accept && !flush) s1_illegal <= dec_illegal;
            if (!flush && s2_load && s1_valid) s2_illegal <= s1_illegal;
        end
    end
`endif

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed spec cases plus randomized traffic
// against a queue-based reference model.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [6:0]  in_opcode, in_func7;
    logic [2:0]  in_func3;
    logic [31:0] in_rs1_val, in_rs2_val, out_result;
    logic [4:0]  in_shamt_imm, in_rd, out_rd;

    always #5 clk = ~clk;

    shift_exec_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_shamt_imm(in_shamt_imm), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    logic        last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: what the op should produce, from the ISA rules directly.
    function automatic bit ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [4:0] imm, input logic [4:0] rd, output exp_t e);
        bit opc_ok, f3_ok, f7_ok;
        int amt;
        logic [31:0] r;
        opc_ok = (opc == 7'h33) || (opc == 7'h13);
        f3_ok  = (f3 == 3'd1) || (f3 == 3'd5);
        f7_ok  = (f7 == 7'h00) || (f7 == 7'h20);
        amt    = (opc == 7'h33) ? int'(rs2 % 32) : int'(imm);
        if (f3 == 3'd1)       r = rs1 << amt;
        else if (f7 == 7'h20) r = 32'($signed(rs1) >>> amt);
        else                  r = rs1 >> amt;
`ifdef SHIFT_ILLEGAL_CHECK_EN
        if (!(opc_ok && f3_ok && f7_ok) || (f7 == 7'h20 && f3 == 3'd1)) e = '{32'd0, rd, 1'b1};
        else                                                           e = '{r, rd, 1'b0};
        return 1'b1;
`else
        e = '{r, rd, 1'b0};
        return opc_ok && f3_ok && f7_ok;
`endif
    endfunction

    task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [4:0] imm, input logic [4:0] rd);
        in_valid = 1'b1; in_opcode = opc; in_func3 = f3; in_func7 = f7;
        in_rs1_val = rs1; in_rs2_val = rs2; in_shamt_imm = imm; in_rd = rd;
    endtask

    // One clock: check outputs against the model, account for the edge, advance to next negedge.
    task automatic cycle();
        exp_t e;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", out_result, prev_res);
            chk("hold_rd", 32'(out_rd), 32'(prev_rd));
        end
        if (out_valid) begin
            chk("no_spurious", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("result", out_result, q[0].res);
                chk("rd", 32'(out_rd), 32'(q[0].rd));
                chk("illegal", 32'(out_illegal), 32'(q[0].ill));
                if (out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
        prev_stall = out_valid && !out_ready && !flush && !rst;
        prev_res   = out_result;
        prev_rd    = out_rd;
        last_acc   = in_valid && in_ready && !rst && !flush;
        if (rst || flush) q.delete();
        else if (in_valid && in_ready) begin
            if (ref_op(in_opcode, in_func3, in_func7, in_rs1_val, in_rs2_val, in_shamt_imm, in_rd, e))
                q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp);
        int n = 0;
        #1;
        while (!out_valid && n < 8) begin
            cycle();
            #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, out_result, exp);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(7'h33, 3'd1, 7'h00, 32'd0, 32'd0, 5'd0, 5'd0);
        in_valid = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // SLLI latency: accept at N, visible at N+2.
        set_op(7'h13, 3'd1, 7'h00, 32'h1, 32'h0, 5'd4, 5'd3);
        cycle();
        in_valid = 1'b0;
        #1;
        chk("slli_n1_valid", 32'(out_valid), 32'd0);
        cycle();
        #1;
        chk("slli_n2_valid", 32'(out_valid), 32'd1);
        chk("slli_result", out_result, 32'h00000010);
        drain("slli_drain");

        set_op(7'h33, 3'd5, 7'h00, 32'hF0000000, 32'hFFFFFFE4, 5'd0, 5'd5);
        cycle(); in_valid = 1'b0;
        wait_result("srl", 32'h0F000000);
        drain("srl_drain");
        set_op(7'h33, 3'd5, 7'h20, 32'hF0000000, 32'hFFFFFFE4, 5'd0, 5'd6);
        cycle(); in_valid = 1'b0;
        wait_result("sra", 32'hFF000000);
        drain("sra_drain");
        set_op(7'h13, 3'd5, 7'h20, 32'h80000000, 32'h0, 5'd31, 5'd7);
        cycle(); in_valid = 1'b0;
        wait_result("srai31", 32'hFFFFFFFF);
        drain("srai_drain");
        set_op(7'h33, 3'd1, 7'h00, 32'h12345678, 32'hFFFFFFE0, 5'd9, 5'd8);
        cycle(); in_valid = 1'b0;
        wait_result("sll_amt0", 32'h12345678);
        drain("sll0_drain");

        // Stream of 8 with a 3-cycle writeback stall mid-stream.
        pops = 0;
        begin
            int cyc = 0;
            for (int i = 0; i < 8; i++) begin
                int tries = 0;
                set_op(($urandom_range(1) != 0) ? 7'h33 : 7'h13, ($urandom_range(1) != 0) ? 3'd1 : 3'd5,
                       ($urandom_range(1) != 0) ? 7'h20 : 7'h00, $urandom, $urandom,
                       5'($urandom_range(31)), 5'(i + 1));
                do begin
                    out_ready = !(cyc >= 3 && cyc < 6);
                    cycle();
                    cyc++;
                    tries++;
                end while (!last_acc && tries < 10);
                chk("stream_accept", 32'(last_acc), 32'd1);
            end
        end
        drain("stream_drain");
        chk("stream_count", 32'(pops), 32'd8);

        // Flush with S1 and S2 full and a third op presented.
        out_ready = 1'b0;
        set_op(7'h13, 3'd1, 7'h00, 32'h3, 32'h0, 5'd1, 5'd10);
        cycle();
        set_op(7'h13, 3'd1, 7'h00, 32'h5, 32'h0, 5'd2, 5'd11);
        cycle();
        set_op(7'h13, 3'd1, 7'h00, 32'h7, 32'h0, 5'd3, 5'd12);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("flush_no_out", 32'(out_valid), 32'd0);
            cycle();
        end
        set_op(7'h13, 3'd1, 7'h00, 32'h1, 32'h0, 5'd8, 5'd13);
        cycle(); in_valid = 1'b0;
        wait_result("post_flush", 32'h00000100);
        drain("flush_drain");

        // Illegal encodings.
        set_op(7'b0110111, 3'd1, 7'h00, 32'hAAAA5555, 32'h1, 5'd1, 5'd14);
        cycle(); in_valid = 1'b0;
`ifdef SHIFT_ILLEGAL_CHECK_EN
        wait_result("bad_opc", 32'd0);
        chk("bad_opc_flag", 32'(out_illegal), 32'd1);
`else
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bad_opc_no_out", 32'(out_valid), 32'd0);
            cycle();
        end
`endif
        drain("bad_opc_drain");
        set_op(7'h33, 3'd5, 7'b0000001, 32'hAAAA5555, 32'h1, 5'd1, 5'd15);
        cycle(); in_valid = 1'b0;
`ifdef SHIFT_ILLEGAL_CHECK_EN
        wait_result("bad_f7", 32'd0);
        chk("bad_f7_flag", 32'(out_illegal), 32'd1);
`else
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bad_f7_no_out", 32'(out_valid), 32'd0);
            cycle();
        end
`endif
        drain("bad_f7_drain");

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        set_op(7'h33, 3'd1, 7'h00, 32'h9, 32'h2, 5'd0, 5'd16);
        cycle();
        set_op(7'h33, 3'd1, 7'h00, 32'hB, 32'h3, 5'd0, 5'd17);
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_stall_no_out", 32'(out_valid), 32'd0);
            cycle();
        end

        // Randomized traffic with backpressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            logic [6:0] opc;
            logic [2:0] f3;
            logic [6:0] f7;
            case ($urandom_range(9))
                0:       opc = 7'($urandom);
                1, 2, 3: opc = 7'h13;
                default: opc = 7'h33;
            endcase
            case ($urandom_range(9))
                0:          f3 = 3'($urandom);
                1, 2, 3, 4: f3 = 3'd1;
                default:    f3 = 3'd5;
            endcase
            case ($urandom_range(9))
                0:          f7 = 7'($urandom);
                1, 2, 3, 4: f7 = 7'h20;
                default:    f7 = 7'h00;
            endcase
            set_op(opc, f3, f7, $urandom, $urandom, 5'($urandom), 5'($urandom));
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(49) == 0);
            cycle();
        end
        flush = 1'b0;
        drain("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
